mem_bus_arbiter: RTL and testbench

//  Two-master to one-slave bus arbiter placed directly upstream of the unified instruction/data memory.

---
 rtl/mem_bus_arbiter_pkg.sv | 51 +++++
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mem_bus_arbiter_rr_arb2.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 110 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter: FSM states, master IDs
// and the registered request bundle presented to the memory.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    typedef enum logic {
        M_INSTR = 1'b0,
        M_DATA  = 1'b1
    } master_e;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic        half_w;
        logic        signext;
    } bus_req_t;

    // Instruction fetches are read-only word accesses, so every field but the address is zero.
    function automatic bus_req_t make_req(
        input master_e     who,
        input logic [31:0] i_adr,
        input logic [31:0] d_adr,
        input logic [31:0] d_dat,
        input logic        d_we,
        input logic        d_half_w,
        input logic        d_signext
    );
        bus_req_t r;
        r = '0;
        if (who == M_DATA) begin
            r.adr     = d_adr;
            r.dat     = d_dat;
            r.we      = d_we;
            r.half_w  = d_half_w;
            r.signext = d_signext;
        end else begin
            r.adr = i_adr;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle around the arbiter: CPU instruction/data master ports plus the
// single request/response path toward the unified memory.
interface mem_bus_arbiter_if;

    logic        i_stb;
    logic [31:0] i_adr;
    logic [31:0] i_dat_o;
    logic        i_ack;

    logic        d_stb;
    logic        d_we;
    logic [31:0] d_adr;
    logic [31:0] d_dat_i;
    logic        d_half_w;
    logic        d_signext;
    logic [31:0] d_dat_o;
    logic        d_ack;

    logic        err_o;

    logic        m_stb_o;
    logic        m_we_o;
    logic        m_half_w_o;
    logic        m_signext_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic        m_ack_i;
    logic [31:0] m_dat_i;

    // The arbiter's view: it serves the CPU masters and fronts the memory.
    modport slave (
        input  i_stb, i_adr, d_stb, d_we, d_adr, d_dat_i, d_half_w, d_signext,
        input  m_ack_i, m_dat_i,
        output i_dat_o, i_ack, d_dat_o, d_ack, err_o,
        output m_stb_o, m_we_o, m_half_w_o, m_signext_o, m_adr_o, m_dat_o
    );

    // The surrounding CPU ports and memory model.
    modport master (
        output i_stb, i_adr, d_stb, d_we, d_adr, d_dat_i, d_half_w, d_signext,
        output m_ack_i, m_dat_i,
        input  i_dat_o, i_ack, d_dat_o, d_ack, err_o,
        input  m_stb_o, m_we_o, m_half_w_o, m_signext_o, m_adr_o, m_dat_o
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, and under
// contention the master that was not granted last time wins.
module rr_arb2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  master_e    last_gnt,
    output master_e    gnt,
    output logic       valid
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        valid = |req;
        gnt   = M_INSTR;
        case (req)
            2'b01:   gnt = M_INSTR;
            2'b10:   gnt = M_DATA;
            2'b11:   gnt = (last_gnt == M_INSTR) ? M_DATA : M_INSTR;
            default: gnt = M_INSTR;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master to one-slave arbiter in front of the unified memory: round-robin
// grant, registered request, one-cycle read latency, ack/err pulse back.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    master_e           gnt_q, last_gnt_q, pick;
    logic              pick_valid;
    logic [CNT_W-1:0]  cnt_q;
    logic              timed_out_q;
    logic              m_stb_q;
    bus_req_t          req_q;
    logic [31:0]       i_dat_q, d_dat_q;
    logic              timeout_hit;

    rr_arb2 u_rr_arb2 (
        .req      ({bus.d_stb, bus.i_stb}),
        .last_gnt (last_gnt_q),
        .gnt      (pick),
        .valid    (pick_valid)
    );

    // The counter value reaches TIMEOUT on the edge that leaves REQ.
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid) state_d = ST_REQ;
            ST_REQ: begin
                if (bus.m_ack_i)      state_d = ST_WAIT;
                else if (timeout_hit) state_d = ST_ACK;
            end
            ST_WAIT: state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= M_INSTR;
            last_gnt_q  <= M_INSTR;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            m_stb_q     <= 1'b0;
            req_q       <= '0;
            i_dat_q     <= '0;
            d_dat_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_q       <= pick;
                        last_gnt_q  <= pick;
                        req_q       <= make_req(pick, bus.i_adr, bus.d_adr, bus.d_dat_i,
                                                bus.d_we, bus.d_half_w, bus.d_signext);
                        m_stb_q     <= 1'b1;
                        cnt_q       <= '0;
                        timed_out_q <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    if (bus.m_ack_i) begin
                        m_stb_q <= 1'b0;
                    end else if (timeout_hit) begin
                        m_stb_q     <= 1'b0;
                        timed_out_q <= 1'b1;
                    end
                end
                // Read data arrives the cycle after m_ack_i; writes load it too.
                ST_WAIT: begin
                    if (gnt_q == M_INSTR) i_dat_q <= bus.m_dat_i;
                    else                  d_dat_q <= bus.m_dat_i;
                end
                default: ;
            endcase
        end
    end

    assign bus.m_stb_o     = m_stb_q;
    assign bus.m_adr_o     = req_q.adr;
    assign bus.m_dat_o     = req_q.dat;
    assign bus.m_we_o      = req_q.we;
    assign bus.m_half_w_o  = req_q.half_w;
    assign bus.m_signext_o = req_q.signext;

    assign bus.i_dat_o = i_dat_q;
    assign bus.d_dat_o = d_dat_q;
    assign bus.i_ack   = (state_q == ST_ACK) && (gnt_q == M_INSTR);
    assign bus.d_ack   = (state_q == ST_ACK) && (gnt_q == M_DATA);
    assign bus.err_o   = (state_q == ST_ACK) && timed_out_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single fetch, contention, half-word write,
// alternating back-to-back grants, timeout with err, and reset mid-transaction.
module tb_mem_bus_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        slave_en = 1'b1;
    logic [31:0] slave_adr = '0;
    logic [31:0] exp_i_dat = '0;

    // Memory contents as seen by the slave model.
    function automatic logic [31:0] rdata(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return (a ^ 32'hC0DE_0000) + 32'h11;
    endfunction

    // Slave: acks in the first REQ cycle, returns data the following cycle.
    initial begin
        bus.m_ack_i = 1'b0;
        bus.m_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.m_ack_i) begin
                bus.m_ack_i = 1'b0;
                bus.m_dat_i = rdata(slave_adr);
            end else if (slave_en && bus.m_stb_o) begin
                bus.m_ack_i = 1'b1;
                slave_adr   = bus.m_adr_o;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs;
        bus.i_stb = 1'b0; bus.i_adr = '0;
        bus.d_stb = 1'b0; bus.d_we = 1'b0; bus.d_adr = '0; bus.d_dat_i = '0;
        bus.d_half_w = 1'b0; bus.d_signext = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic wait_ack(input bit want_d, input int budget, output bit seen, output int stb_cycles);
        seen = 1'b0;
        stb_cycles = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick;
            if (want_d ? bus.d_ack : bus.i_ack) seen = 1'b1;
            else if (bus.m_stb_o)               stb_cycles++;
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bus.m_stb_o !== 1'b0) begin n_bad++; $display("FAIL rst_m_stb: got %b want 0", bus.m_stb_o); end
        n_cmp++; if ({bus.i_ack, bus.d_ack, bus.err_o} !== 3'b000) begin n_bad++; $display("FAIL rst_acks: got %b want 000", {bus.i_ack, bus.d_ack, bus.err_o}); end
        n_cmp++; if (bus.m_adr_o !== 32'h0) begin n_bad++; $display("FAIL rst_m_adr: got %h want 0", bus.m_adr_o); end
        n_cmp++; if ({bus.i_dat_o, bus.d_dat_o} !== 64'h0) begin n_bad++; $display("FAIL rst_dat: got %h want 0", {bus.i_dat_o, bus.d_dat_o}); end
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single_instr;
        bus.i_adr = 32'h100;
        bus.i_stb = 1'b1;
        tick;
        n_cmp++; if (bus.m_stb_o !== 1'b1) begin n_bad++; $display("FAIL t1_m_stb: got %b want 1", bus.m_stb_o); end
        n_cmp++; if (bus.m_adr_o !== 32'h100) begin n_bad++; $display("FAIL t1_m_adr: got %h want 100", bus.m_adr_o); end
        n_cmp++; if (bus.m_we_o !== 1'b0) begin n_bad++; $display("FAIL t1_m_we: got %b want 0", bus.m_we_o); end
        tick;
        n_cmp++; if (bus.i_ack !== 1'b0) begin n_bad++; $display("FAIL t1_early_ack: got %b want 0", bus.i_ack); end
        tick;
        n_cmp++; if (bus.i_ack !== 1'b1) begin n_bad++; $display("FAIL t1_ack_c3: got %b want 1", bus.i_ack); end
        n_cmp++; if (bus.i_dat_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL t1_i_dat: got %h want deadbeef", bus.i_dat_o); end
        n_cmp++; if ({bus.err_o, bus.d_ack} !== 2'b00) begin n_bad++; $display("FAIL t1_err_dack: got %b want 00", {bus.err_o, bus.d_ack}); end
        bus.i_stb = 1'b0;
        tick;
        n_cmp++; if (bus.i_ack !== 1'b0) begin n_bad++; $display("FAIL t1_ack_pulse: got %b want 0", bus.i_ack); end
        n_cmp++; if (bus.i_dat_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL t1_i_dat_hold: got %h want deadbeef", bus.i_dat_o); end
    endtask

    task automatic test_contention;
        logic [31:0] first_adr;
        logic        prev_stb;
        int          rises, i_cnt, d_cnt, both, first_d;
        first_adr = '0; prev_stb = 1'b0;
        rises = 0; i_cnt = 0; d_cnt = 0; both = 0; first_d = -1;
        do_reset();
        bus.i_adr = 32'h300; bus.d_adr = 32'h400; bus.d_we = 1'b0;
        bus.i_stb = 1'b1;    bus.d_stb = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick;
            if (bus.m_stb_o && !prev_stb) begin
                if (rises == 0) first_adr = bus.m_adr_o;
                rises++;
            end
            prev_stb = bus.m_stb_o;
            if (bus.i_ack && bus.d_ack) both++;
            if (bus.d_ack) begin
                d_cnt++;
                if (first_d < 0) first_d = 1;
                bus.d_stb = 1'b0;
            end
            if (bus.i_ack) begin
                i_cnt++;
                if (first_d < 0) first_d = 0;
                bus.i_stb = 1'b0;
            end
        end
        exp_i_dat = rdata(32'h300);
        n_cmp++; if (first_adr !== 32'h400) begin n_bad++; $display("FAIL t2_first_grant: got %h want 400", first_adr); end
        n_cmp++; if (first_d != 1) begin n_bad++; $display("FAIL t2_first_ack_data: got %0d want 1", first_d); end
        n_cmp++; if (rises != 2) begin n_bad++; $display("FAIL t2_stb_rises: got %0d want 2", rises); end
        n_cmp++; if (i_cnt != 1 || d_cnt != 1) begin n_bad++; $display("FAIL t2_ack_counts: got i=%0d d=%0d want 1/1", i_cnt, d_cnt); end
        n_cmp++; if (both != 0) begin n_bad++; $display("FAIL t2_ack_overlap: got %0d want 0", both); end
        n_cmp++; if (bus.d_dat_o !== rdata(32'h400)) begin n_bad++; $display("FAIL t2_d_dat: got %h want %h", bus.d_dat_o, rdata(32'h400)); end
        n_cmp++; if (bus.i_dat_o !== exp_i_dat) begin n_bad++; $display("FAIL t2_i_dat: got %h want %h", bus.i_dat_o, exp_i_dat); end
    endtask

    task automatic test_half_write;
        bit seen;
        int cyc;
        bus.d_adr = 32'h202; bus.d_we = 1'b1; bus.d_half_w = 1'b1;
        bus.d_signext = 1'b0; bus.d_dat_i = 32'h0000_BEEF;
        bus.d_stb = 1'b1;
        tick;
        n_cmp++; if ({bus.m_stb_o, bus.m_we_o, bus.m_half_w_o, bus.m_signext_o} !== 4'b1110) begin
            n_bad++; $display("FAIL t3_m_ctrl: got %b want 1110", {bus.m_stb_o, bus.m_we_o, bus.m_half_w_o, bus.m_signext_o}); end
        n_cmp++; if (bus.m_adr_o !== 32'h202) begin n_bad++; $display("FAIL t3_m_adr: got %h want 202", bus.m_adr_o); end
        n_cmp++; if (bus.m_dat_o !== 32'h0000_BEEF) begin n_bad++; $display("FAIL t3_m_dat: got %h want 0000beef", bus.m_dat_o); end
        wait_ack(1'b1, 10, seen, cyc);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t3_d_ack: got none want ack within 10"); end
        n_cmp++; if ({bus.err_o, bus.i_ack} !== 2'b00) begin n_bad++; $display("FAIL t3_err_iack: got %b want 00", {bus.err_o, bus.i_ack}); end
        n_cmp++; if (bus.i_dat_o !== exp_i_dat) begin n_bad++; $display("FAIL t3_i_dat_untouched: got %h want %h", bus.i_dat_o, exp_i_dat); end
        bus.d_stb = 1'b0;
        tick;
        bus.d_adr = 32'h206; bus.d_we = 1'b0; bus.d_signext = 1'b1; bus.d_dat_i = 32'h1234_5678;
        bus.d_stb = 1'b1;
        tick;
        n_cmp++; if ({bus.m_stb_o, bus.m_we_o, bus.m_half_w_o, bus.m_signext_o} !== 4'b1011) begin
            n_bad++; $display("FAIL t3_signext_ctrl: got %b want 1011", {bus.m_stb_o, bus.m_we_o, bus.m_half_w_o, bus.m_signext_o}); end
        wait_ack(1'b1, 10, seen, cyc);
        n_cmp++; if (!seen || bus.d_dat_o !== rdata(32'h206)) begin
            n_bad++; $display("FAIL t3_half_read: got ack=%b dat=%h want ack=1 dat=%h", seen, bus.d_dat_o, rdata(32'h206)); end
        bus.d_stb = 1'b0; bus.d_half_w = 1'b0; bus.d_signext = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        logic prev_stb;
        int   grants, acks, i_acks, d_acks;
        prev_stb = 1'b0; grants = 0; acks = 0; i_acks = 0; d_acks = 0;
        do_reset();
        bus.i_adr = 32'h1000; bus.d_adr = 32'h2000; bus.d_we = 1'b0;
        bus.i_stb = 1'b1;     bus.d_stb = 1'b1;
        for (int c = 0; c < 60 && acks < 8; c++) begin
            tick;
            if (bus.m_stb_o && !prev_stb) begin
                n_cmp++;
                if ((bus.m_adr_o >= 32'h2000) !== (grants % 2 == 0)) begin
                    n_bad++; $display("FAIL t4_grant%0d: got adr %h want %s", grants, bus.m_adr_o, (grants % 2 == 0) ? "data" : "instr");
                end
                grants++;
            end
            prev_stb = bus.m_stb_o;
            if (bus.d_ack) begin
                n_cmp++; if (bus.d_dat_o !== rdata(bus.d_adr)) begin n_bad++; $display("FAIL t4_d_dat: got %h want %h", bus.d_dat_o, rdata(bus.d_adr)); end
                bus.d_adr = bus.d_adr + 32'd4;
                d_acks++; acks++;
            end
            if (bus.i_ack) begin
                exp_i_dat = rdata(bus.i_adr);
                bus.i_adr = bus.i_adr + 32'd4;
                i_acks++; acks++;
            end
            if (acks == 8) begin
                bus.i_stb = 1'b0;
                bus.d_stb = 1'b0;
            end
        end
        n_cmp++; if (grants != 8) begin n_bad++; $display("FAIL t4_grant_count: got %0d want 8", grants); end
        n_cmp++; if (i_acks != 4 || d_acks != 4) begin n_bad++; $display("FAIL t4_fairness: got i=%0d d=%0d want 4/4", i_acks, d_acks); end
        n_cmp++; if (bus.i_dat_o !== exp_i_dat) begin n_bad++; $display("FAIL t4_i_dat: got %h want %h", bus.i_dat_o, exp_i_dat); end
        tick;
    endtask

    task automatic test_timeout;
        bit seen;
        int req_cyc;
        slave_en = 1'b0;
        bus.i_adr = 32'h500;
        bus.i_stb = 1'b1;
        wait_ack(1'b0, 40, seen, req_cyc);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t5_ack: got none want ack within 40"); end
        n_cmp++; if (req_cyc != 15) begin n_bad++; $display("FAIL t5_req_cycles: got %0d want 15", req_cyc); end
        n_cmp++; if (bus.err_o !== 1'b1) begin n_bad++; $display("FAIL t5_err: got %b want 1", bus.err_o); end
        n_cmp++; if (bus.i_dat_o !== exp_i_dat) begin n_bad++; $display("FAIL t5_i_dat_kept: got %h want %h", bus.i_dat_o, exp_i_dat); end
        bus.i_stb = 1'b0;
        tick;
        n_cmp++; if ({bus.err_o, bus.i_ack} !== 2'b00) begin n_bad++; $display("FAIL t5_err_pulse: got %b want 00", {bus.err_o, bus.i_ack}); end
        slave_en = 1'b1;
        bus.d_adr = 32'h600; bus.d_we = 1'b0;
        bus.d_stb = 1'b1;
        wait_ack(1'b1, 10, seen, req_cyc);
        n_cmp++; if (!seen || bus.err_o !== 1'b0 || bus.d_dat_o !== rdata(32'h600)) begin
            n_bad++; $display("FAIL t5_recover: got ack=%b err=%b dat=%h want 1/0/%h", seen, bus.err_o, bus.d_dat_o, rdata(32'h600)); end
        bus.d_stb = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        bit   found, seen;
        logic prev_stb;
        int   stray, cyc;
        found = 1'b0; prev_stb = 1'b0; stray = 0;
        bus.d_adr = 32'h700; bus.d_we = 1'b0;
        bus.d_stb = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            tick;
            if (prev_stb && !bus.m_stb_o) found = 1'b1;
            prev_stb = bus.m_stb_o;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL t6_reach_wait: got no stb fall want fall within 10"); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.m_stb_o, bus.i_ack, bus.d_ack, bus.err_o} !== 4'b0000) begin
            n_bad++; $display("FAIL t6_rst_ctrl: got %b want 0000", {bus.m_stb_o, bus.i_ack, bus.d_ack, bus.err_o}); end
        n_cmp++; if ({bus.m_adr_o, bus.d_dat_o, bus.i_dat_o} !== 96'h0) begin
            n_bad++; $display("FAIL t6_rst_data: got %h want 0", {bus.m_adr_o, bus.d_dat_o, bus.i_dat_o}); end
        bus.d_stb = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (bus.i_ack || bus.d_ack || bus.m_stb_o) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL t6_stale: got %0d active cycles want 0", stray); end
        bus.i_adr = 32'h800;
        bus.i_stb = 1'b1;
        wait_ack(1'b0, 10, seen, cyc);
        n_cmp++; if (!seen || bus.i_dat_o !== rdata(32'h800) || bus.err_o !== 1'b0) begin
            n_bad++; $display("FAIL t6_fresh: got ack=%b dat=%h err=%b want 1/%h/0", seen, bus.i_dat_o, bus.err_o, rdata(32'h800)); end
        bus.i_stb = 1'b0;
        tick;
    endtask

    initial begin
        test_reset();
        test_single_instr();
        test_contention();
        test_half_write();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
